gpr_access_ctrl: RTL and testbench

GPR_ACCESS_CTRL -- requirements
Module: gpr_access_ctrl

---
 rtl/gpr_pkg.sv | 39 +++
 rtl/gpr_bus_drv.sv | 13 +
 rtl/gpr_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_gpr_access_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared definitions for the GPR access controller:
// register index names, FSM state encoding and a small state helper.
package gpr_pkg;

    localparam int unsigned GPR_IDX_W = 4;

    localparam logic [GPR_IDX_W-1:0] REG_AX    = 4'd0;
    localparam logic [GPR_IDX_W-1:0] REG_BX    = 4'd1;
    localparam logic [GPR_IDX_W-1:0] REG_CX    = 4'd2;
    localparam logic [GPR_IDX_W-1:0] REG_DX    = 4'd3;
    localparam logic [GPR_IDX_W-1:0] REG_SI    = 4'd4;
    localparam logic [GPR_IDX_W-1:0] REG_DI    = 4'd5;
    localparam logic [GPR_IDX_W-1:0] REG_BP    = 4'd6;
    localparam logic [GPR_IDX_W-1:0] REG_SP    = 4'd7;
    localparam logic [GPR_IDX_W-1:0] REG_FLAGS = 4'd8;
    localparam logic [GPR_IDX_W-1:0] REG_AX1   = 4'd9;
    localparam logic [GPR_IDX_W-1:0] REG_AX2   = 4'd10;
    localparam logic [GPR_IDX_W-1:0] REG_AX3   = 4'd11;
    localparam logic [GPR_IDX_W-1:0] REG_AX4   = 4'd12;
    localparam logic [GPR_IDX_W-1:0] REG_AX5   = 4'd13;
    localparam logic [GPR_IDX_W-1:0] REG_AX6   = 4'd14;
    localparam logic [GPR_IDX_W-1:0] REG_AX7   = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WB    = 3'd1,
        S_RD_A  = 3'd2,
        S_RD_B  = 3'd3,
        S_CAP_B = 3'd4,
        S_CAP_A = 3'd5,
        S_OUT   = 3'd6
    } gpr_state_t;

    // States that issue a read command on the register-file bus.
    function automatic logic is_rd_state(gpr_state_t s);
        return (s == S_RD_A) || (s == S_RD_B);
    endfunction

endpackage

// File: rtl/gpr_bus_drv.sv
// Tristate driver for the shared register-file data bus.
// Ports: en_i (drive enable), data_i (value to drive), bus_io (shared bus).
module gpr_bus_drv #(
    parameter int DATA_W = 14
) (
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    inout  wire  [DATA_W-1:0] bus_io
);

    assign bus_io = en_i ? data_i : {DATA_W{1'bz}};

endmodule

// File: rtl/gpr_access_ctrl.sv
// Arbitrates writebacks and operand fetches onto a register-file bus.
// Ports: req_* operand request, wb_* writeback, op_* operand result,
//        gpr_* register-file bus (addr, bidir data, rd/wr strobes).
module gpr_access_ctrl
    import gpr_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W-1:0]  req_src_a,
    input  logic [IDX_W-1:0]  req_src_b,
    input  logic              req_two,

    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [IDX_W-1:0]  wb_dst,
    input  logic [DATA_W-1:0] wb_data,

    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,

    output logic [ADDR_W-1:0] gpr_addr,
    inout  wire  [DATA_W-1:0] gpr_data,
    output logic              gpr_rd,
    output logic              gpr_wr
);

    gpr_state_t        state_q, state_d;

    logic [IDX_W-1:0]  dst_q;
    logic [DATA_W-1:0] wdata_q;
    logic [IDX_W-1:0]  src_a_q;
    logic [IDX_W-1:0]  src_b_q;
    logic              two_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic              drv_en;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; writeback has priority over a fetch request
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (wb_valid) begin
                    state_d = S_WB;
                end else if (req_valid) begin
                    state_d = S_RD_A;
                end
            end
            S_WB:    state_d = S_IDLE;
            S_RD_A:  state_d = two_q ? S_RD_B : S_CAP_A;
            S_RD_B:  state_d = S_CAP_B;
            S_CAP_B: state_d = S_OUT;
            S_CAP_A: state_d = S_OUT;
            S_OUT: begin
                if (op_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = 1'b0;
        wb_ready  = 1'b0;
        op_valid  = 1'b0;
        gpr_rd    = is_rd_state(state_q);
        gpr_wr    = 1'b0;
        gpr_addr  = '0;
        drv_en    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                wb_ready  = 1'b1;
            end
            S_WB: begin
                gpr_wr   = 1'b1;
                gpr_addr = ADDR_W'(dst_q);
                drv_en   = 1'b1;
            end
            S_RD_A:  gpr_addr = ADDR_W'(src_a_q);
            S_RD_B:  gpr_addr = ADDR_W'(src_b_q);
            S_OUT:   op_valid = 1'b1;
            default: ;
        endcase
    end

    // Request/writeback latches and operand capture. Read data shows up
    // on the bus one cycle after the read strobe, so operand A lands
    // while B's read is being issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            dst_q   <= '0;
            wdata_q <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            two_q   <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (wb_valid) begin
                        dst_q   <= wb_dst;
                        wdata_q <= wb_data;
                    end else if (req_valid) begin
                        src_a_q <= req_src_a;
                        src_b_q <= req_src_b;
                        two_q   <= req_two;
                    end
                end
                S_RD_B:  op_a_q <= gpr_data;
                S_CAP_B: op_b_q <= gpr_data;
                S_CAP_A: begin
                    op_a_q <= gpr_data;
                    op_b_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign op_a = op_a_q;
    assign op_b = op_b_q;

    gpr_bus_drv #(
        .DATA_W (DATA_W)
    ) u_drv (
        .en_i   (drv_en),
        .data_i (wdata_q),
        .bus_io (gpr_data)
    );

endmodule

// File: tb/tb_gpr_access_ctrl.sv
// Directed self-checking bench for gpr_access_ctrl with a
// behavioural register file on the gpr_* bus.
module tb_gpr_access_ctrl;
    import gpr_pkg::*;

    localparam int DW = 14;
    localparam int AW = 12;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_two;
    logic [IW-1:0] req_src_a, req_src_b;
    logic          wb_valid, wb_ready;
    logic [IW-1:0] wb_dst;
    logic [DW-1:0] wb_data;
    logic          op_valid, op_ready;
    logic [DW-1:0] op_a, op_b;
    logic [AW-1:0] gpr_addr;
    wire  [DW-1:0] gpr_data;
    logic          gpr_rd, gpr_wr;

    int errors = 0;
    int checks = 0;
    int both_cnt = 0;

    logic [DW-1:0] rf [16];
    logic          rd_pend = 1'b0;
    logic [DW-1:0] rd_data = '0;

    always #5 clk = ~clk;

    gpr_access_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .IDX_W  (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src_a (req_src_a),
        .req_src_b (req_src_b),
        .req_two   (req_two),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_dst    (wb_dst),
        .wb_data   (wb_data),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .gpr_addr  (gpr_addr),
        .gpr_data  (gpr_data),
        .gpr_rd    (gpr_rd),
        .gpr_wr    (gpr_wr)
    );

    // Register file: synchronous write, read data one cycle after gpr_rd
    assign gpr_data = rd_pend ? rd_data : {DW{1'bz}};

    always @(posedge clk) begin
        if (gpr_wr) rf[gpr_addr[3:0]] <= gpr_data;
        rd_pend <= gpr_rd;
        if (gpr_rd) rd_data <= rf[gpr_addr[3:0]];
        if (gpr_rd && gpr_wr) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        check({tag, ".req_ready"}, 32'(req_ready), 1);
        check({tag, ".op_valid"}, 32'(op_valid), 0);
        check({tag, ".gpr_rd"}, 32'(gpr_rd), 0);
        check({tag, ".gpr_wr"}, 32'(gpr_wr), 0);
        check({tag, ".addr"}, 32'(gpr_addr), 0);
        check({tag, ".bus_drv"}, 32'(dut.u_drv.en_i), 0);
    endtask

    task automatic wb(input logic [IW-1:0] d, input logic [DW-1:0] v);
        wb_valid = 1'b1;
        wb_dst   = d;
        wb_data  = v;
        check("wb.ready", 32'(wb_ready), 1);
        step();
        wb_valid = 1'b0;
        check("wb.wr", 32'(gpr_wr), 1);
        check("wb.addr", 32'(gpr_addr), 32'(d));
        check("wb.data", 32'(gpr_data), 32'(v));
        step();
        check("wb.done", 32'(gpr_wr), 0);
    endtask

    task automatic rd(input string tag, input logic [IW-1:0] a,
                      input logic [IW-1:0] b, input logic two,
                      input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                      input int hold);
        int cyc;
        req_valid = 1'b1;
        req_src_a = a;
        req_src_b = b;
        req_two   = two;
        step();
        req_valid = 1'b0;
        cyc = 1;
        check({tag, ".rd_a_addr"}, 32'(gpr_addr), 32'(a));
        check({tag, ".wb_ready"}, 32'(wb_ready), 0);
        while (!op_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check({tag, ".latency"}, 32'(cyc), two ? 4 : 3);
        check({tag, ".op_a"}, 32'(op_a), 32'(ea));
        check({tag, ".op_b"}, 32'(op_b), 32'(eb));
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, ".hold_v"}, 32'(op_valid), 1);
            check({tag, ".hold_a"}, 32'(op_a), 32'(ea));
            check({tag, ".hold_b"}, 32'(op_b), 32'(eb));
            check({tag, ".hold_rr"}, 32'(req_ready), 0);
        end
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        check({tag, ".done"}, 32'(op_valid), 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_src_a = '0;
        req_src_b = '0;
        req_two   = 1'b0;
        wb_valid  = 1'b0;
        wb_dst    = '0;
        wb_data   = '0;
        op_ready  = 1'b0;
        step();
        step();
        check("rst.op_a", 32'(op_a), 0);
        check("rst.op_b", 32'(op_b), 0);
        check("rst.wb_ready", 32'(wb_ready), 1);
        idle_chk("rst");
        rst = 1'b0;

        // Preload and two-operand fetch
        wb(REG_BX, 14'h0123);
        wb(REG_CX, 14'h0456);
        rd("two", REG_BX, REG_CX, 1'b1, 14'h0123, 14'h0456, 0);

        // Coincident writeback and request: write goes first
        wb_valid  = 1'b1;
        wb_dst    = REG_DX;
        wb_data   = 14'h3FFF;
        req_valid = 1'b1;
        req_src_a = REG_DX;
        req_src_b = REG_AX;
        req_two   = 1'b0;
        step();
        wb_valid = 1'b0;
        check("coin.wr", 32'(gpr_wr), 1);
        check("coin.rd", 32'(gpr_rd), 0);
        check("coin.req_ready", 32'(req_ready), 0);
        step();
        rd("coin", REG_DX, REG_AX, 1'b0, 14'h3FFF, 14'h0, 0);

        // Backpressure in OUT
        rd("hold", REG_CX, REG_BX, 1'b1, 14'h0456, 14'h0123, 5);

        // Reset during RD_B
        req_valid = 1'b1;
        req_src_a = REG_BX;
        req_src_b = REG_CX;
        req_two   = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check("rstb.in_rd_b", 32'(gpr_addr), 32'(REG_CX));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstb.op_a", 32'(op_a), 0);
        idle_chk("rstb");

        // Back-to-back FLAGS writes then read
        wb(REG_FLAGS, 14'h0001);
        wb(REG_FLAGS, 14'h2000);
        rd("flags", REG_FLAGS, REG_AX, 1'b0, 14'h2000, 14'h0, 0);

        // Same source twice
        wb(REG_AX7, 14'h1555);
        rd("same", REG_AX7, REG_AX7, 1'b1, 14'h1555, 14'h1555, 0);

        idle_chk("end");
        check("rd_wr_both", 32'(both_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
